seq_gen_1011: RTL and testbench
===============================

Name: seq_gen_1011

Overview:
- Serial pattern transmitter: on request, emits a fixed bit pattern (default 1011, MSB first) a programmable number of times on a one-bit stream.
- Optional zero-filled gaps between repetitions.
- Drives the stimulus side of the team's serial sequence-detection path, and provides a self-contained pattern source for bring-up and loopback checks.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern, transmitted MSB (bit PAT_W-1) first.
- CNT_W, 8, width of the repetition count and frames_sent.
- GAP_W, 4, width of the inter-pattern gap length.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- repeat_cnt  in  CNT_W  number of patterns to send; latched on an accepted start.
- gap_len  in  GAP_W  zero cycles between patterns; latched on an accepted start.
- abort  in  1  terminate the current transfer.
- out_bit  out  1  serial data, registered.
- out_valid  out  1  high while a pattern bit is on out_bit.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a transfer completes normally.
- frames_sent  out  CNT_W  patterns completed in the current or last transfer.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_bit, out_valid, busy, done = 0; frames_sent = 0; internal counters = 0. A reset mid-transfer kills the transfer immediately and produces no done pulse.
- All outputs are registered. Wording below: "at edge k" means a value sampled at rising edge k; that value is visible from edge k+1.
- States:
  - IDLE: idle.
  - SEND: shifting pattern bits out, bit index PAT_W-1 down to 0.
  - GAP: gap_len cycles with out_bit=0, out_valid=0.
  - DONE: one cycle, done=1.
- Accepted start (IDLE, start=1, abort=0, repeat_cnt!=0) at edge k:
  - latch repeat_cnt and gap_len; clear frames_sent.
  - first pattern bit on out_bit with out_valid=1 from edge k+1.
- One bit per cycle in SEND.
- After bit 0 of a pattern:
  - frames_sent increments; the new value is visible in the following cycle.
  - If the remaining count is above 1 and gap_len>0: go to GAP.
  - If the remaining count is above 1 and gap_len=0: next pattern starts back-to-back, no idle cycle.
  - If the remaining count is 1: go to DONE, then IDLE.
- start with repeat_cnt=0: no bits are sent; go to DONE directly (done pulses at edge k+1); frames_sent=0.
- start while busy: ignored; latched values are unchanged.
- abort in SEND or GAP:
  - state=IDLE at the next edge; out_valid=0; out_bit=0; no done pulse.
  - frames_sent holds the count of completed patterns only.
- abort in IDLE or DONE: no effect, except that abort together with start in IDLE wins and the start is dropped.
- Width rules:
  - Counters do not wrap: the maximum repeat_cnt is 2^CNT_W-1, and frames_sent reaches exactly that value.
  - The gap counter counts gap_len down to 0.
- Outside SEND: out_bit=0.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined: after bit 0 of each pattern, one extra cycle in SEND with out_valid=1 and out_bit = even parity of PATTERN (XOR of all bits; 1 for 1011). The frame is PAT_W+1 bits, and frames_sent increments after the parity bit.
- Undefined: the frame is exactly PAT_W bits and there is no parity logic.

Decomposition:
- Shared package seq_pkg:
  - state typedef (IDLE, SEND, GAP, DONE).
  - default PATTERN and PAT_W constants, shared with the detection side so both ends agree on the sequence.
- Sub-module seq_gen_shifter:
  - loadable PAT_W-bit shift register with bit-index counter.
  - output flags last_bit (and the parity bit when the macro is enabled).
  - the FSM and the repeat/gap counters stay in seq_gen_1011.

Test Plan:
- Reset checks: hold reset=0 and check all outputs are 0. Release, then pulse start with repeat_cnt=1, gap_len=0 at edge k → out_bit 1,0,1,1 at cycles k+1..k+4 with out_valid=1; done=1 at k+5; busy=1 for k+1..k+5; frames_sent=1.
- Back-to-back: repeat_cnt=3, gap_len=0 → 12 contiguous bits 101110111011; done at k+13; frames_sent=3.
- Gaps: repeat_cnt=2, gap_len=2 → 1011, then 00 with out_valid=0, then 1011; done at k+11.
- Abort and reset mid-transfer:
  - repeat_cnt=4, abort asserted during the 3rd bit of pattern 2 → IDLE at the next edge, no done, frames_sent=1.
  - A start pulsed during busy is ignored.
  - reset=0 mid-pattern zeroes all outputs asynchronously, before the next edge.
- Edge cases:
  - start with repeat_cnt=0 → no out_valid; done at k+1.
  - start+abort in the same IDLE cycle → nothing happens.
  - repeat_cnt=255 → frames_sent=255, with no wrap.
- SEQ_GEN_PARITY_EN defined, repeat_cnt=2 → 10111 10111; done at k+11.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path: FSM states and the default
// pattern that both the generator and the detector agree on.
package seq_pkg;

  localparam int unsigned SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_gen_1011_if.sv
// Control/status bundle of the serial pattern generator.
interface seq_gen_1011_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);

  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, repeat_cnt, gap_len, abort,
    input  out_bit, out_valid, busy, done, frames_sent
  );

  modport slave (
    input  start, repeat_cnt, gap_len, abort,
    output out_bit, out_valid, busy, done, frames_sent
  );

endinterface

// File: rtl/seq_gen_shifter.sv
// Loadable pattern shift register with a bit-index counter; MSB is the serial bit.
// With SEQ_GEN_PARITY_EN defined, the even parity of the pattern is appended as an extra bit.
module seq_gen_shifter #(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic shift,
  input  logic clear,
  output logic out_bit,
  output logic last_bit
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned      SR_W     = PAT_W + 1;
  localparam logic [SR_W-1:0]  LOAD_VAL = {PATTERN, ^PATTERN};
`else
  localparam int unsigned      SR_W     = PAT_W;
  localparam logic [SR_W-1:0]  LOAD_VAL = PATTERN;
`endif
  localparam int unsigned IDX_W = $clog2(SR_W);

  logic [SR_W-1:0]  sreg;
  logic [IDX_W-1:0] idx;

  // clear wins over load so an abort or frame end always parks the line at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      idx  <= '0;
    end else if (clear) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= LOAD_VAL;
      idx  <= IDX_W'(SR_W - 1);
    end else if (shift) begin
      sreg <= {sreg[SR_W-2:0], 1'b0};
      idx  <= idx - IDX_W'(1);
    end
  end

  assign out_bit  = sreg[SR_W-1];
  assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_gen_1011.sv
// Serial pattern transmitter: sends PATTERN repeat_cnt times with optional zero gaps.
// Optional feature macro: SEQ_GEN_PARITY_EN (appends an even-parity bit to every frame).
module seq_gen_1011
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
  parameter int unsigned      CNT_W   = 8,
  parameter int unsigned      GAP_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_gen_1011_if.slave   bus
);

  state_t           state, state_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic [CNT_W-1:0] frames, frames_d;
  logic [GAP_W-1:0] gap, gap_d;
  logic [GAP_W-1:0] gcnt, gcnt_d;
  logic             load, shift, clear;
  logic             sh_bit, last_bit;
  logic             out_valid, busy, done;

  seq_gen_shifter #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .clear    (clear),
    .out_bit  (sh_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      frames    <= '0;
      gap       <= '0;
      gcnt      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      frames    <= frames_d;
      gap       <= gap_d;
      gcnt      <= gcnt_d;
      out_valid <= (state_d == SEND);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
    end
  end

  // next-state, counter updates and shifter control
  always_comb begin
    state_d  = state;
    rem_d    = rem;
    frames_d = frames;
    gap_d    = gap;
    gcnt_d   = gcnt;
    load     = 1'b0;
    shift    = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          rem_d    = bus.repeat_cnt;
          gap_d    = bus.gap_len;
          frames_d = '0;
          gcnt_d   = '0;
          if (bus.repeat_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            load    = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (last_bit) begin
          frames_d = frames + CNT_W'(1);
          rem_d    = rem - CNT_W'(1);
          if (rem > CNT_W'(1)) begin
            if (gap != '0) begin
              state_d = GAP;
              gcnt_d  = gap;
              clear   = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_d = DONE;
            clear   = 1'b1;
          end
        end else begin
          shift = 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
          gcnt_d  = '0;
        end else if (gcnt == GAP_W'(1)) begin
          state_d = SEND;
          gcnt_d  = '0;
          load    = 1'b1;
        end else begin
          gcnt_d = gcnt - GAP_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_bit     = sh_bit;
  assign bus.out_valid   = out_valid;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.frames_sent = frames;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Randomized self-checking bench for seq_gen_1011 against a per-cycle stream model.
module tb_seq_gen_1011;

  localparam logic [3:0] PAT = 4'b1011;
`ifdef SEQ_GEN_PARITY_EN
  localparam int FRAME_W = 5;
`else
  localparam int FRAME_W = 4;
`endif

  typedef struct packed {
    logic       valid;
    logic       b;
    logic       busy;
    logic       done;
    logic [7:0] frames;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_frames = 0;
  obs_t exp_q[$];

  seq_gen_1011_if #(.CNT_W(8), .GAP_W(4)) bus ();

  seq_gen_1011 #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .CNT_W   (8),
    .GAP_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {bus.out_valid, bus.out_bit, bus.busy, bus.done, bus.frames_sent};
  endfunction

  function automatic obs_t mk(logic v, logic b, logic bz, logic d, int fr);
    obs_t o;
    o.valid = v; o.b = b; o.busy = bz; o.done = d; o.frames = 8'(fr);
    return o;
  endfunction

  // Expected per-cycle view from the cycle after the accepted start through the done pulse
  function automatic void build_expected(int rep, int gap);
    exp_q.delete();
    for (int f = 0; f < rep; f++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, PAT[3-i], 1'b1, 1'b0, f));
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back(mk(1'b1, ^PAT, 1'b1, 1'b0, f));
`endif
      if (f < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, f + 1));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, rep));
  endfunction

  task automatic launch(int rep, int gap);
    @(negedge clk);
    bus.start = 1'b1;
    bus.repeat_cnt = 8'(rep);
    bus.gap_len = 4'(gap);
    @(negedge clk);
    bus.start = 1'b0;
    bus.repeat_cnt = 8'($urandom);
    bus.gap_len = 4'($urandom);
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b0; bus.repeat_cnt = 8'd3; bus.gap_len = 4'd0;
    repeat (3) @(negedge clk);
    o = observe();
    vectors++;
    if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", o, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    o = observe();
    vectors++;
    if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", o, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
  endtask

  task automatic test_stream(string name, int rep, int gap);
    obs_t o;
    build_expected(rep, gap);
    launch(rep, gap);
    foreach (exp_q[i]) begin
      o = observe();
      vectors++;
      if (o !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s rep=%0d gap=%0d cycle %0d: got %h want %h", name, rep, gap, i, o, exp_q[i]);
      end
      @(negedge clk);
    end
    o = observe();
    vectors++;
    if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, rep)) begin
      miscompares++;
      $display("FAIL %s_idle: got %h want %h", name, o, mk(1'b0, 1'b0, 1'b0, 1'b0, rep));
    end
    last_frames = rep;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      test_stream("random", int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_start_abort();
    obs_t o;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.repeat_cnt = 8'd3; bus.gap_len = 4'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      o = observe();
      vectors++;
      if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, last_frames)) begin
        miscompares++;
        $display("FAIL start_abort cycle %0d: got %h want %h", c, o, mk(1'b0, 1'b0, 1'b0, 1'b0, last_frames));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    obs_t o;
    build_expected(2, 1);
    launch(2, 1);
    foreach (exp_q[i]) begin
      o = observe();
      vectors++;
      if (o !== exp_q[i]) begin
        miscompares++;
        $display("FAIL busy_start cycle %0d: got %h want %h", i, o, exp_q[i]);
      end
      bus.start = (i == 2 || i == 5);
      if (bus.start) begin
        bus.repeat_cnt = 8'd7;
        bus.gap_len = 4'd0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    last_frames = 2;
  endtask

  task automatic test_abort();
    obs_t o;
    build_expected(4, 0);
    launch(4, 0);
    for (int i = 0; i <= FRAME_W + 2; i++) begin
      o = observe();
      vectors++;
      if (o !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_pre cycle %0d: got %h want %h", i, o, exp_q[i]);
      end
      if (i == FRAME_W + 2) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      o = observe();
      vectors++;
      if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1)) begin
        miscompares++;
        $display("FAIL abort_post cycle %0d: got %h want %h", c, o, mk(1'b0, 1'b0, 1'b0, 1'b0, 1));
      end
      @(negedge clk);
    end
    last_frames = 1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    launch(3, 0);
    repeat (FRAME_W + 1) @(negedge clk);
    #2 reset = 1'b0;
    #1 o = observe();
    vectors++;
    if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h", o, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = observe();
      vectors++;
      if (o !== mk(1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
        miscompares++;
        $display("FAIL reset_after cycle %0d: got %h want %h", c, o, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream("single", 1, 0);
    test_stream("back_to_back", 3, 0);
    test_stream("gaps", 2, 2);
    test_random();
    test_start_abort();
    test_start_while_busy();
    test_abort();
    test_stream("zero", 0, int'($urandom_range(0, 15)));
    test_stream("max", 255, 0);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
